// File: rtl/q_run_sequencer.sv
// Sequencer for one greedy Q-table exploitation run: holds the current cell for the
// policy datapath, hands each chosen move to the move driver, and reports the outcome.
module q_run_sequencer #(
  parameter int STATE_W    = 6,
  parameter int NUM_STATES = 37,
  parameter int MAX_STEPS  = 64,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_start,
  input  logic               abort,
  input  logic [STATE_W-1:0] start_state,
  input  logic [STATE_W-1:0] target_state,
  input  logic [STATE_W-1:0] next_state,
  input  logic               move_ack,
  output logic [STATE_W-1:0] maze_state,
  output logic [STATE_W-1:0] move_target,
  output logic               move_req,
  output logic               move_complete,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [1:0]         fail_code,
  output logic [7:0]         step_count
);

  localparam int VIS_N = 1 << STATE_W;
  localparam logic [STATE_W:0] NUM_STATES_W = (STATE_W + 1)'(NUM_STATES);
  localparam logic [7:0] MAX_STEPS_W = 8'(MAX_STEPS);
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ISSUE, S_WAIT_ACK, S_UPDATE, S_DONE, S_FAIL
  } state_t;

  state_t             state_reg, state_next;
  logic [STATE_W-1:0] maze_reg, maze_next;
  logic [STATE_W-1:0] target_reg, target_next;
  logic [STATE_W-1:0] move_target_reg, move_target_next;
  logic               move_req_reg, move_req_next;
  logic               move_complete_reg, move_complete_next;
  logic               done_reg, done_next;
  logic               fail_reg, fail_next;
  logic [1:0]         fail_code_reg, fail_code_next;
  logic [7:0]         step_reg, step_next;
  logic [7:0]         cnt_reg, cnt_next;
  // Visited bitmap spans the whole index space so out-of-range cells index safely.
  logic [VIS_N-1:0]   visited_reg, visited_next;
  logic               busy_int;

  assign busy_int = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_FAIL);

  always_comb begin
    state_next         = state_reg;
    maze_next          = maze_reg;
    target_next        = target_reg;
    move_target_next   = move_target_reg;
    move_req_next      = move_req_reg;
    move_complete_next = 1'b0;
    done_next          = done_reg;
    fail_next          = fail_reg;
    fail_code_next     = fail_code_reg;
    step_next          = step_reg;
    cnt_next           = cnt_reg;
    visited_next       = visited_reg;

    // Abort outranks everything, including an ack arriving in the same cycle.
    if (abort && busy_int) begin
      state_next     = S_FAIL;
      move_req_next  = 1'b0;
      fail_next      = 1'b1;
      fail_code_next = 2'd3;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_FAIL: begin
          if (run_start) begin
            state_next   = S_SETTLE;
            maze_next    = start_state;
            target_next  = target_state;
            step_next    = 8'd0;
            visited_next = '0;
            visited_next[start_state] = 1'b1;
            done_next    = 1'b0;
            fail_next    = 1'b0;
            cnt_next     = SETTLE_INIT;
          end
        end
        S_SETTLE: begin
          if (cnt_reg != 8'd0) begin
            cnt_next = cnt_reg - 8'd1;
          end else if (maze_reg == target_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else if (step_reg == MAX_STEPS_W) begin
            state_next     = S_FAIL;
            fail_next      = 1'b1;
            fail_code_next = 2'd0;
          end else if (({1'b0, next_state} >= NUM_STATES_W) || (next_state == maze_reg)) begin
            state_next     = S_FAIL;
            fail_next      = 1'b1;
            fail_code_next = 2'd1;
          end else if (visited_reg[next_state]) begin
            state_next     = S_FAIL;
            fail_next      = 1'b1;
            fail_code_next = 2'd2;
          end else begin
            state_next       = S_ISSUE;
            move_target_next = next_state;
          end
        end
        S_ISSUE: begin
          move_req_next = 1'b1;
          state_next    = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (move_ack) begin
            move_req_next = 1'b0;
            state_next    = S_UPDATE;
          end
        end
        S_UPDATE: begin
          maze_next          = move_target_reg;
          visited_next[move_target_reg] = 1'b1;
          step_next          = step_reg + 8'd1;
          move_complete_next = 1'b1;
          cnt_next           = SETTLE_INIT;
          state_next         = S_SETTLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      maze_reg          <= '0;
      target_reg        <= '0;
      move_target_reg   <= '0;
      move_req_reg      <= 1'b0;
      move_complete_reg <= 1'b0;
      done_reg          <= 1'b0;
      fail_reg          <= 1'b0;
      fail_code_reg     <= 2'd0;
      step_reg          <= 8'd0;
      cnt_reg           <= 8'd0;
      visited_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      maze_reg          <= maze_next;
      target_reg        <= target_next;
      move_target_reg   <= move_target_next;
      move_req_reg      <= move_req_next;
      move_complete_reg <= move_complete_next;
      done_reg          <= done_next;
      fail_reg          <= fail_next;
      fail_code_reg     <= fail_code_next;
      step_reg          <= step_next;
      cnt_reg           <= cnt_next;
      visited_reg       <= visited_next;
    end
  end

  assign maze_state    = maze_reg;
  assign move_target   = move_target_reg;
  assign move_req      = move_req_reg;
  assign move_complete = move_complete_reg;
  assign busy          = busy_int;
  assign done          = done_reg;
  assign fail          = fail_reg;
  assign fail_code     = fail_code_reg;
  assign step_count    = step_reg;

endmodule

// File: tb/tb_q_run_sequencer.sv
// Bench for q_run_sequencer: directed vector table, randomized runs against a path-walking
// reference model, and a mid-run reset sequence.
module tb_q_run_sequencer;

  localparam int SW   = 6;
  localparam int NS   = 37;
  localparam int MAXS = 4;
  localparam int SC   = 4;

  logic          clk = 1'b0;
  logic          rst, run_start, abort, move_ack;
  logic [SW-1:0] start_state, target_state, next_state;
  logic [SW-1:0] maze_state, move_target;
  logic          move_req, move_complete, busy, done, fail;
  logic [1:0]    fail_code;
  logic [7:0]    step_count;

  always #5 clk = ~clk;

  q_run_sequencer #(.STATE_W(SW), .NUM_STATES(NS), .MAX_STEPS(MAXS), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .run_start(run_start), .abort(abort),
    .start_state(start_state), .target_state(target_state), .next_state(next_state),
    .move_ack(move_ack), .maze_state(maze_state), .move_target(move_target),
    .move_req(move_req), .move_complete(move_complete), .busy(busy), .done(done),
    .fail(fail), .fail_code(fail_code), .step_count(step_count)
  );

  // Policy datapath stand-in: a lookup table indexed by the current cell.
  logic [SW-1:0] pol [64];
  assign next_state = pol[maze_state];

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int got_q[$];

  typedef struct {
    bit dn;
    int code;
    int maze;
    int steps;
    int reqs;
  } res_t;

  typedef struct {
    int s; int t; int kind; int dly; int abk; bit poke; bit abst;
    bit dn; int code; int maze; int steps; int reqs;
  } vec_t;

  task automatic chk(input string nm, input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", nm, what, got, exp);
    end
  endtask

  task automatic set_policy(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: pol[i] = SW'((i + 1) % 64);
        1: pol[i] = (i == 6) ? SW'(5) : SW'((i + 1) % 64);
        2: pol[i] = SW'(40);
        default: pol[i] = SW'(i);
      endcase
    end
  endtask

  // Walks the greedy path by the run rules; fills exp_q with the cells requested.
  function automatic res_t model(input int s, input int t, input int abort_k);
    res_t r;
    bit   vis [64];
    int   cur, n;
    for (int i = 0; i < 64; i++) vis[i] = 1'b0;
    exp_q.delete();
    cur = s; vis[s] = 1'b1;
    r.dn = 0; r.code = 0; r.steps = 0; r.reqs = 0; r.maze = s;
    for (int it = 0; it < 300; it++) begin
      if (cur == t) begin r.dn = 1; break; end
      if (r.steps == MAXS) begin r.code = 0; break; end
      n = int'(pol[cur]);
      if (n >= NS || n == cur) begin r.code = 1; break; end
      if (vis[n]) begin r.code = 2; break; end
      r.reqs++;
      exp_q.push_back(n);
      if (r.steps == abort_k) begin r.code = 3; break; end
      vis[n] = 1'b1;
      cur = n;
      r.steps++;
    end
    r.maze = cur;
    return r;
  endfunction

  task automatic do_run(input string nm, input int s, input int t, input int dly, input int abk,
                        input bit poke, input bit abst, input res_t e);
    int cyc, acks, ncomp, last_launch, ack_cyc, req_cyc;
    bit prev_req, term;
    got_q.delete();
    start_state = SW'(s); target_state = SW'(t); run_start = 1'b1; abort = abst;
    @(posedge clk); #1;
    run_start = 1'b0; abort = 1'b0;
    chk(nm, "busy_start", busy, 1);
    acks = 0; ncomp = 0; last_launch = 0; ack_cyc = -100; req_cyc = 0;
    prev_req = 1'b0; term = 1'b0; cyc = 0;
    for (int i = 1; i <= 300 && !term; i++) begin
      @(posedge clk); #1;
      cyc = i;
      move_ack = 1'b0; abort = 1'b0; run_start = 1'b0;
      if (move_complete) begin
        ncomp++;
        chk(nm, "ack_to_complete", cyc - ack_cyc, 2);
        last_launch = cyc;
      end
      if (move_req && !prev_req) begin
        got_q.push_back(int'(move_target));
        req_cyc = cyc;
        // Edges from entering SETTLE to move_req: SETTLE_CYC in SETTLE plus one in ISSUE.
        chk(nm, "req_latency", cyc - last_launch, SC + 1);
        if (poke && got_q.size() == 1) begin
          run_start = 1'b1; start_state = SW'(20); target_state = SW'(20);
        end
      end else if (move_req) begin
        chk(nm, "target_stable", int'(move_target), got_q[$]);
      end
      prev_req = move_req;
      if (done || fail) begin
        term = 1'b1;
        if (fail && fail_code == 2'd3) chk(nm, "abort_latency", cyc - ack_cyc, 1);
        else chk(nm, "end_latency", cyc - last_launch, SC);
      end else if (move_req && (cyc - req_cyc) == dly) begin
        move_ack = 1'b1;
        abort = (acks == abk);
        ack_cyc = cyc;
        acks++;
      end
    end
    move_ack = 1'b0; abort = 1'b0; run_start = 1'b0;
    if (!term) chk(nm, "timeout", 0, 1);
    chk(nm, "done", done, int'(e.dn));
    chk(nm, "fail", fail, int'(!e.dn));
    if (!e.dn) chk(nm, "fail_code", fail_code, e.code);
    chk(nm, "maze_state", maze_state, e.maze);
    chk(nm, "step_count", step_count, e.steps);
    chk(nm, "req_count", got_q.size(), e.reqs);
    chk(nm, "complete_count", ncomp, e.steps);
    chk(nm, "busy_end", busy, 0);
    chk(nm, "req_end", move_req, 0);
    for (int k = 0; k < exp_q.size(); k++)
      chk(nm, "move_target", (k < got_q.size()) ? got_q[k] : -1, exp_q[k]);
    // Abort outside a run must be ignored and the result must hold.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(nm, "hold_done", done, int'(e.dn));
    chk(nm, "hold_fail", fail, int'(!e.dn));
    if (!e.dn) chk(nm, "hold_code", fail_code, e.code);
    chk(nm, "hold_maze", maze_state, e.maze);
    chk(nm, "hold_steps", step_count, e.steps);
  endtask

  vec_t vecs [12];
  res_t r, e;

  initial begin
    rst = 1'b1; run_start = 1'b0; abort = 1'b0; move_ack = 1'b0;
    start_state = '0; target_state = '0;
    set_policy(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "maze_state", maze_state, 0);
    chk("reset", "move_target", move_target, 0);
    chk("reset", "move_req", move_req, 0);
    chk("reset", "move_complete", move_complete, 0);
    chk("reset", "busy", busy, 0);
    chk("reset", "done", done, 0);
    chk("reset", "fail", fail, 0);
    chk("reset", "fail_code", fail_code, 0);
    chk("reset", "step_count", step_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    //          s   t   kind dly abk poke abst dn code maze steps reqs
    vecs[0]  = '{0,  3,  0,  3, -1, 1, 0, 1, 0, 3,  3, 3};
    vecs[1]  = '{5,  20, 1,  1, -1, 0, 0, 0, 2, 6,  1, 1};
    vecs[2]  = '{0,  36, 0,  0, -1, 0, 0, 0, 0, 4,  4, 4};
    vecs[3]  = '{2,  9,  2,  2, -1, 0, 0, 0, 1, 2,  0, 0};
    vecs[4]  = '{8,  9,  3,  2, -1, 0, 0, 0, 1, 8,  0, 0};
    vecs[5]  = '{0,  3,  0,  2,  0, 0, 0, 0, 3, 0,  0, 1};
    vecs[6]  = '{7,  7,  0,  2, -1, 0, 1, 1, 0, 7,  0, 0};
    vecs[7]  = '{50, 3,  0,  1, -1, 0, 0, 0, 1, 50, 0, 0};
    vecs[8]  = '{50, 50, 0,  1, -1, 0, 0, 1, 0, 50, 0, 0};
    vecs[9]  = '{0,  4,  0,  1, -1, 0, 0, 1, 0, 4,  4, 4};
    vecs[10] = '{35, 0,  0,  4, -1, 0, 0, 0, 1, 36, 1, 1};
    vecs[11] = '{10, 30, 0,  1,  1, 0, 0, 0, 3, 11, 1, 2};

    for (int v = 0; v < 12; v++) begin
      set_policy(vecs[v].kind);
      r = model(vecs[v].s, vecs[v].t, vecs[v].abk);
      e.dn = vecs[v].dn; e.code = vecs[v].code; e.maze = vecs[v].maze;
      e.steps = vecs[v].steps; e.reqs = vecs[v].reqs;
      do_run($sformatf("vec%0d", v), vecs[v].s, vecs[v].t, vecs[v].dly, vecs[v].abk,
             vecs[v].poke, vecs[v].abst, e);
      $display("vec%0d start=%0d target=%0d -> done=%0d fail=%0d code=%0d maze=%0d steps=%0d",
               v, vecs[v].s, vecs[v].t, done, fail, fail_code, maze_state, step_count);
    end

    for (int n = 0; n < 40; n++) begin
      int s, t, dly, abk;
      for (int i = 0; i < 64; i++)
        pol[i] = ($urandom_range(0, 9) == 0) ? SW'(i) : SW'($urandom_range(0, 39));
      s   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(37, 45)) : int'($urandom_range(0, 36));
      t   = ($urandom_range(0, 1) == 0) ? int'(pol[pol[s]]) : int'($urandom_range(0, 36));
      dly = int'($urandom_range(0, 4));
      abk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      r = model(s, t, abk);
      do_run($sformatf("rnd%0d", n), s, t, dly, abk, 1'b0, 1'b0, r);
      $display("rnd%0d start=%0d target=%0d dly=%0d abort_k=%0d -> done=%0d code=%0d maze=%0d steps=%0d",
               n, s, t, dly, abk, done, fail_code, maze_state, step_count);
    end

    // Reset while a move request is outstanding.
    begin
      bit seen;
      set_policy(0);
      seen = 1'b0;
      start_state = SW'(0); target_state = SW'(30); run_start = 1'b1;
      @(posedge clk); #1;
      run_start = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        seen = move_req;
      end
      chk("midrst", "req_reached", int'(seen), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst", "move_req", move_req, 0);
      chk("midrst", "busy", busy, 0);
      chk("midrst", "maze_state", maze_state, 0);
      chk("midrst", "step_count", step_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst", "done", done, 0);
      chk("midrst", "fail", fail, 0);
      chk("midrst", "move_target", move_target, 0);
      $display("midrst -> move_req=%0d busy=%0d maze=%0d steps=%0d", move_req, busy, maze_state, step_count);
      r = model(3, 3, -1);
      do_run("post_rst", 3, 3, 1, -1, 1'b0, 1'b0, r);
      $display("post_rst start=3 target=3 -> done=%0d steps=%0d", done, step_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
